// File: rtl/feature_line_buffer.sv
// Assembles a serial 32-bit sample stream into an N-slot feature vector (bias in slot 0) with valid/ready on both sides.
// Optional sliding-window mode is enabled by defining LINEBUF_SLIDE_EN.
module feature_line_buffer #(
  parameter int unsigned N         = 41,
  parameter int unsigned FIRST_IDX = 2,
  parameter logic [31:0] BIAS_VAL  = 32'd1,
  parameter int unsigned CW        = 16,
  localparam int unsigned DW       = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in_data,
  input  logic          in_valid,
  input  logic          in_sof,
  output logic          in_ready,
  output logic [DW-1:0] xarray [0:N-1],
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] vec_count
);

  localparam int unsigned IW        = $clog2(N);
  localparam logic [IW-1:0] IDX_FIRST = IW'(FIRST_IDX);
  localparam logic [IW-1:0] IDX_NEXT  = IW'(FIRST_IDX + 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(N - 1);

`ifdef LINEBUF_SLIDE_EN
  typedef enum logic [1:0] {FILL = 2'd0, FULL = 2'd1, PRIMED = 2'd2} state_e;
`else
  typedef enum logic [0:0] {FILL = 1'b0, FULL = 1'b1} state_e;
`endif

  state_e             state_q, state_d;
  logic [IW-1:0]      wr_idx_q, wr_idx_d;
  logic [DW-1:0]      slots_q [FIRST_IDX:N-1];
  logic [DW-1:0]      slots_d [FIRST_IDX:N-1];
  logic [CW-1:0]      vec_count_q, vec_count_d;
  logic               out_hs;
  logic               in_acc;

  // A waiting vector only blocks the input until the consumer takes it.
  assign in_ready = (state_q != FULL) || out_ready;
  assign out_hs   = (state_q == FULL) && out_ready;
  assign in_acc   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    slots_d     = slots_q;
    vec_count_d = vec_count_q;

    if (out_hs) begin
      vec_count_d = vec_count_q + CW'(1);
    end

    if (in_acc && in_sof) begin
      for (int unsigned i = FIRST_IDX + 1; i < N; i++) begin
        slots_d[IW'(i)] = '0;
      end
      slots_d[IDX_FIRST] = in_data;
      wr_idx_d           = IDX_NEXT;
      state_d            = FILL;
    end else begin
      unique case (state_q)
        FILL: begin
          if (in_acc) begin
            for (int unsigned i = FIRST_IDX; i < N; i++) begin
              if (wr_idx_q == IW'(i)) begin
                slots_d[IW'(i)] = in_data;
              end
            end
            if (wr_idx_q == IDX_LAST) begin
              state_d  = FULL;
              wr_idx_d = IDX_FIRST;
            end else begin
              wr_idx_d = wr_idx_q + IW'(1);
            end
          end
        end
        FULL: begin
          if (out_hs) begin
`ifdef LINEBUF_SLIDE_EN
            // A sample arriving with the handshake slides the window and re-presents at once.
            if (in_acc) begin
              for (int unsigned i = FIRST_IDX; i < N - 1; i++) begin
                slots_d[IW'(i)] = slots_q[IW'(i + 1)];
              end
              slots_d[IDX_LAST] = in_data;
            end else begin
              state_d = PRIMED;
            end
`else
            if (in_acc) begin
              slots_d[IDX_FIRST] = in_data;
              wr_idx_d           = IDX_NEXT;
            end
            state_d = FILL;
`endif
          end
        end
`ifdef LINEBUF_SLIDE_EN
        PRIMED: begin
          if (in_acc) begin
            for (int unsigned i = FIRST_IDX; i < N - 1; i++) begin
              slots_d[IW'(i)] = slots_q[IW'(i + 1)];
            end
            slots_d[IDX_LAST] = in_data;
            state_d           = FULL;
          end
        end
`endif
        default: begin
          state_d = FILL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      wr_idx_q    <= IDX_FIRST;
      slots_q     <= '{default: '0};
      vec_count_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      slots_q     <= slots_d;
      vec_count_q <= vec_count_d;
    end
  end

  // Slot 0 is the bias term; slots below FIRST_IDX are tied to zero.
  assign xarray[0] = BIAS_VAL;
  for (genvar g = 1; g < FIRST_IDX; g++) begin : g_zero
    assign xarray[g] = '0;
  end
  for (genvar g = FIRST_IDX; g < N; g++) begin : g_slot
    assign xarray[g] = slots_q[g];
  end

  assign out_valid = (state_q == FULL);
  assign vec_count = vec_count_q;

endmodule

// File: doc/feature_line_buffer.md
# feature_line_buffer

Upstream feeder for the logistic-regression inner-product stage. Accepts a serial stream of 32-bit feature samples with a valid/ready handshake and assembles them into the 41-entry feature vector (`xarray[0:40]`) that the inner-product stage consumes. Slot 0 carries the constant bias term. Slots below `FIRST_IDX` other than slot 0 are held at zero. Vectors are presented with a valid/ready handshake so the consumer can be pipelined or stalled.

## Interface
- `N`, 41: vector length, including bias and unused slots.
- `FIRST_IDX`, 2: first slot filled from the stream; slots `FIRST_IDX..N-1` are loaded, giving `N-FIRST_IDX` samples per vector (39 by default).
- `BIAS_VAL`, 32'd1: constant driven on slot 0.
- `CW`, 16: width of the vector counter.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_data` in 32: feature sample.
- `in_valid` in 1: sample valid.
- `in_sof` in 1: start of frame, qualified by `in_valid`.
- `in_ready` out 1: sample accepted when `in_valid && in_ready`.
- `xarray [0:N-1]` out 32 each: assembled vector.
- `out_valid` out 1: `xarray` holds a complete vector.
- `out_ready` in 1: consumer takes the vector when `out_valid && out_ready`.
- `vec_count` out CW: count of completed output handshakes; wraps modulo 2^CW.

## Operation
- **States:**
  - FILL: collecting samples.
  - FULL: vector presented.
  - PRIMED: exists only with the slide macro; window holds the last `N-FIRST_IDX-1` samples and awaits one more.
- **Write index `wr_idx`:** runs `FIRST_IDX..N-1`.
  - Each accepted sample writes `xarray[wr_idx]` and increments `wr_idx`.
  - Accepting at `wr_idx==N-1` moves to FULL.
- **`in_ready`:** 1 in FILL and PRIMED. In FULL, `in_ready = out_ready`, so a new sample can be accepted in the same cycle the vector is consumed.
- **FULL with output handshake:**
  - No sample accepted: go to FILL (block mode) or PRIMED (slide mode).
  - Sample accepted in the same cycle (block mode): it goes to slot `FIRST_IDX`, `wr_idx` becomes `FIRST_IDX+1`, state becomes FILL.
- **`in_sof` on an accepted sample:**
  - Discards any partial window; the sample is written to `FIRST_IDX` and `wr_idx` becomes `FIRST_IDX+1`.
  - Slots `FIRST_IDX+1..N-1` are cleared to 0.
  - State becomes FILL. In FULL this only occurs together with an output handshake, so the presented vector is never lost.
- **Fixed slots:** `xarray[0] = BIAS_VAL`; slots `1..FIRST_IDX-1` are always 0.
- **`vec_count`:** increments on every output handshake; wraps from 2^CW-1 to 0.
- **Data path:** pure move, no arithmetic; samples are stored bit-exact.

## Timing
- **Reset values:**
  - State FILL, `wr_idx=FIRST_IDX`.
  - `out_valid=0`, `in_ready=1`, `vec_count=0`.
  - Slots `FIRST_IDX..N-1` = 0; fixed slots as specified.
- **Latency:** `out_valid` rises on the clock edge that accepts the last sample, so it is visible the cycle after acceptance.
- **Throughput:**
  - Block mode: one vector per `N-FIRST_IDX` accepted samples, with no bubble when `out_ready` is held high.
  - Slide mode (after priming): one vector per sample.
- **Stall stability:** `xarray` and `out_valid` are stable while `out_valid && !out_ready`.
- **Mid-operation reset:** `rst_n` low mid-operation returns all state to reset values immediately. A partial window is lost.
- **Input stall:** `in_valid` low holds all state.

## Configuration
- **`LINEBUF_SLIDE_EN` defined (sliding-window mode):**
  - After the first full vector, an output handshake moves to PRIMED.
  - A sample accepted in FULL (with handshake) or in PRIMED shifts slots `FIRST_IDX+1..N-1` down by one and writes the new sample at `N-1`.
  - `out_valid` is then 1 (state FULL).
  - `in_sof` still restarts a full fill.
- **Undefined (block mode):** vectors are non-overlapping. PRIMED and the shift logic are not compiled.

## Test plan
- **Block fill:** reset, then stream samples 1..39 with `out_ready=1` -> `out_valid` pulses one cycle after sample 39.
  - `xarray[0]=1`, `xarray[1]=0`, `xarray[2..40]=1..39`.
  - `vec_count=1`.
- **Back-pressure:** hold `out_ready=0` after the vector completes, then offer sample 40 -> `in_ready=0`, vector unchanged.
  - Raise `out_ready`: sample 40 is accepted into slot 2 in the same cycle and `out_valid` falls.
- **Frame restart:** 20 samples, then a sample of value 100 with `in_sof=1`, then 38 more -> one vector with `xarray[2]=100`, no vector from the partial window.
- **Counter wrap:** with `CW=2`, complete 5 vectors -> `vec_count` reads 1,2,3,0,1.
- **Mid-operation reset:** `rst_n` low after 10 samples -> `out_valid=0`, `in_ready=1`, `xarray[2..40]=0`.
  - After release, 39 fresh samples produce a correct vector.
- **Slide mode (`LINEBUF_SLIDE_EN`):** stream 1..45 with `out_ready=1` -> 7 vectors.
  - The last vector has `xarray[2]=7` and `xarray[40]=45`.
